rr_packet_arbiter: RTL and testbench

//  Shares one downstream valid/ready channel between N upstream requesters.

---
 rtl/rr_packet_arbiter_pkg.sv | 9 +
 rtl/rr_select.sv | 43 ++++
 rtl/rr_packet_arbiter.sv | 100 ++++++++++
 tb/tb_rr_packet_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_packet_arbiter_pkg.sv
// Shared helpers for the arbiter family.
// Index width never collapses to zero bits, even for a single requester.
package rr_packet_arbiter_pkg;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin pick: the first set request at or after ptr, wrapping at N-1.
// Latency: purely combinational. Backpressure: none; this is only the selection function.
// Outputs are all-zero when no request is set.
module rr_select
  import rr_packet_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  localparam int IW1 = IW + 1;
  localparam logic [IW:0] N_EXT = IW1'(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  pos;
  logic [IW:0]    sum;

  always_comb begin
    dbl = {req, req};
    rot = dbl[ptr +: N];
    any = |req;
    // Descending scan so the lowest rotated position wins.
    pos = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) pos = IW'(i);
    end
    sum = {1'b0, ptr} + {1'b0, pos};
    if (sum >= N_EXT) sum = sum - N_EXT;
    idx = any ? sum[IW-1:0] : '0;
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = any && (idx == IW'(i));
    end
  end

endmodule

// File: rtl/rr_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one valid/ready channel among N requesters.
// Latency: zero-cycle; request, grant and forward all happen in the same cycle.
// Backpressure: out_ready gates in_ready of the granted requester only; grant is frozen while stalled.
module rr_packet_arbiter
  import rr_packet_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int DW = 32,
  parameter bit LOCK_EN = 1'b1,
  localparam int IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  in_valid,
  input  logic [N*DW-1:0] in_data,
  input  logic [N-1:0]  in_last,
  output logic [N-1:0]  in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          locked
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic          lock, lock_nxt;
  logic [IW-1:0] lock_idx, lock_idx_nxt;
  logic [IW-1:0] ptr, ptr_nxt;

  logic [N-1:0]  sel_onehot;
  logic [IW-1:0] sel_idx;
  logic          sel_any;
  logic [N-1:0]  lock_onehot;
  logic          xfer;
  logic          eff_last;

  rr_select #(.N(N)) u_sel (
    .req    (in_valid),
    .ptr    (ptr),
    .onehot (sel_onehot),
    .idx    (sel_idx),
    .any    (sel_any)
  );

  // While locked the held requester owns the channel even if it bubbles.
  always_comb begin
    lock_onehot = '0;
    for (int i = 0; i < N; i++) begin
      lock_onehot[i] = (lock_idx == IW'(i));
    end
    grant     = lock ? lock_onehot : sel_onehot;
    grant_idx = lock ? lock_idx : sel_idx;
    out_valid = lock ? in_valid[lock_idx] : sel_any;
  end

  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      out_data = out_data | (in_data[i*DW +: DW] & {DW{grant[i]}});
      out_last = out_last | (in_last[i] & grant[i]);
    end
  end

  assign in_ready = grant & {N{out_ready}};
  assign xfer     = out_valid & out_ready;
  assign eff_last = out_last | !LOCK_EN;
  assign locked   = lock;

  always_comb begin
    lock_nxt     = lock;
    lock_idx_nxt = lock_idx;
    ptr_nxt      = ptr;
    if (xfer) begin
      if (eff_last) begin
        lock_nxt = 1'b0;
        ptr_nxt  = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      end else begin
        lock_nxt     = 1'b1;
        lock_idx_nxt = grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock     <= 1'b0;
      lock_idx <= '0;
      ptr      <= '0;
    end else begin
      lock     <= lock_nxt;
      lock_idx <= lock_idx_nxt;
      ptr      <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Scoreboard bench: stimulus queues the expected accepted beats, monitors check them on transfer.
module tb_rr_packet_arbiter;

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] data;
    logic        last;
    logic        lock;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [3:0]       v1, l1, v2, l2;
  logic [3:0][31:0] d1, d2;
  logic             r1, r2;

  logic [3:0]  in_ready1, grant1, in_ready2, grant2;
  logic        out_valid1, out_last1, locked1, out_valid2, out_last2, locked2;
  logic [31:0] out_data1, out_data2;
  logic [1:0]  grant_idx1, grant_idx2;

  exp_t q1[$];
  exp_t q2[$];
  int   checks;
  int   failures;

  rr_packet_arbiter #(.N(4), .DW(32), .LOCK_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_data(d1), .in_last(l1),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
    .out_last(out_last1), .out_ready(r1), .grant(grant1),
    .grant_idx(grant_idx1), .locked(locked1)
  );

  rr_packet_arbiter #(.N(4), .DW(32), .LOCK_EN(1'b0)) dut2 (
    .clk(clk), .reset(reset), .in_valid(v2), .in_data(d2), .in_last(l2),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2),
    .out_last(out_last2), .out_ready(r2), .grant(grant2),
    .grant_idx(grant_idx2), .locked(locked2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input int idx, input logic [31:0] data, input logic last, input logic lk);
    exp_t e;
    e.idx  = 2'(idx);
    e.data = data;
    e.last = last;
    e.lock = lk;
    return e;
  endfunction

  // Monitor for the locking instance.
  always @(negedge clk) begin
    if (!reset && out_valid1 && r1) begin
      if (q1.size() == 0) begin
        chk("beat1_unexpected", {31'd0, out_valid1}, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("beat1_idx", {30'd0, grant_idx1}, {30'd0, e.idx});
        chk("beat1_data", out_data1, e.data);
        chk("beat1_last", {31'd0, out_last1}, {31'd0, e.last});
        chk("beat1_locked", {31'd0, locked1}, {31'd0, e.lock});
        chk("beat1_in_ready", {28'd0, in_ready1}, 32'd1 << e.idx);
      end
    end
  end

  // Monitor for the non-locking instance.
  always @(negedge clk) begin
    if (!reset && out_valid2 && r2) begin
      if (q2.size() == 0) begin
        chk("beat2_unexpected", {31'd0, out_valid2}, 32'd0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("beat2_idx", {30'd0, grant_idx2}, {30'd0, e.idx});
        chk("beat2_data", out_data2, e.data);
        chk("beat2_locked", {31'd0, locked2}, {31'd0, e.lock});
        chk("beat2_in_ready", {28'd0, in_ready2}, 32'd1 << e.idx);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    v1 = '0; l1 = '0; d1 = '0; r1 = 1'b0;
    v2 = '0; l2 = '0; d2 = '0; r2 = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state with no requests.
    @(negedge clk);
    chk("rst_grant", {28'd0, grant1}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid1}, 32'd0);
    chk("rst_in_ready", {28'd0, in_ready1}, 32'd0);
    chk("rst_locked", {31'd0, locked1}, 32'd0);
    chk("rst_grant_idx", {30'd0, grant_idx1}, 32'd0);
    chk("rst_out_data", out_data1, 32'd0);

    // Full contention, single-beat packets: plain rotation on both instances.
    for (int i = 0; i < 4; i++) begin
      d1[i] = 32'hA0 + i;
      d2[i] = 32'hB0 + i;
    end
    for (int c = 0; c < 8; c++) begin
      step();
      v1 = 4'b1111; l1 = 4'b1111; r1 = 1'b1;
      v2 = 4'b1111; l2 = 4'b0000; r2 = 1'b1;
      q1.push_back(mk(c % 4, 32'hA0 + (c % 4), 1'b1, 1'b0));
      q2.push_back(mk(c % 4, 32'hB0 + (c % 4), 1'b0, 1'b0));
    end
    step();
    v1 = '0; l1 = '0; v2 = '0;
    @(negedge clk);
    chk("nolock_locked", {31'd0, locked2}, 32'd0);

    // Three-beat packet on req1 while req2 waits.
    for (int b = 0; b < 3; b++) begin
      step();
      v1 = 4'b0110;
      l1 = (b == 2) ? 4'b0110 : 4'b0100;
      d1[1] = 32'h100 + b;
      d1[2] = 32'h200;
      q1.push_back(mk(1, 32'h100 + b, b == 2, b != 0));
    end
    step();
    v1 = 4'b0100;
    q1.push_back(mk(2, 32'h200, 1'b1, 1'b0));

    // Lock on req0 (ptr=3), then req0 bubbles while req3 requests.
    step();
    v1 = 4'b0001; l1 = 4'b0000; d1[0] = 32'h300;
    q1.push_back(mk(0, 32'h300, 1'b0, 1'b0));
    for (int b = 0; b < 2; b++) begin
      step();
      v1 = 4'b1000; l1 = 4'b1000; d1[3] = 32'h3300;
      @(negedge clk);
      chk("bubble_out_valid", {31'd0, out_valid1}, 32'd0);
      chk("bubble_grant", {28'd0, grant1}, 32'd1);
      chk("bubble_in_ready", {28'd0, in_ready1}, 32'd1);
      chk("bubble_locked", {31'd0, locked1}, 32'd1);
    end
    step();
    v1 = 4'b1001; l1 = 4'b1001; d1[0] = 32'h301;
    q1.push_back(mk(0, 32'h301, 1'b1, 1'b1));
    step();
    v1 = 4'b1000;
    q1.push_back(mk(3, 32'h3300, 1'b1, 1'b0));

    // Downstream stall with ptr=0: grant and payload frozen.
    step();
    v1 = 4'b0110; l1 = 4'b0110; r1 = 1'b0;
    d1[1] = 32'h501; d1[2] = 32'h502;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_grant", {28'd0, grant1}, 32'd2);
      chk("stall_out_data", out_data1, 32'h501);
      chk("stall_out_valid", {31'd0, out_valid1}, 32'd1);
      chk("stall_in_ready", {28'd0, in_ready1}, 32'd0);
      step();
    end
    r1 = 1'b1;
    q1.push_back(mk(1, 32'h501, 1'b1, 1'b0));

    // Lock on req2 at ptr=2, then reset mid-packet.
    step();
    v1 = 4'b0100; l1 = 4'b0000; d1[2] = 32'h600;
    q1.push_back(mk(2, 32'h600, 1'b0, 1'b0));
    step();
    v1 = '0; reset = 1'b1;
    @(negedge clk);
    chk("pre_reset_locked", {31'd0, locked1}, 32'd1);
    step();
    reset = 1'b0;
    v1 = 4'b1010; r1 = 1'b0;
    @(negedge clk);
    chk("post_reset_locked", {31'd0, locked1}, 32'd0);
    chk("post_reset_ptr_pick", {30'd0, grant_idx1}, 32'd1);
    step();
    v1 = 4'b1100; l1 = 4'b1100; r1 = 1'b1; d1[2] = 32'h602;
    q1.push_back(mk(2, 32'h602, 1'b1, 1'b0));
    step();
    v1 = '0; l1 = '0;

    for (int k = 0; k < 20 && (q1.size() != 0 || q2.size() != 0); k++) step();
    chk("q1_drained", q1.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
